// File: rtl/fifo_state_addr_pkg.sv
// Shared state codes and size defaults for the 8-entry FIFO control path (fifo_ns, fifo_state_addr).
// Pure definitions: no latency, no flow control.
package fifo_state_addr_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_AW    = 3;
   localparam int FIFO_CW    = 4;

   typedef enum logic [2:0] {
      ST_INIT   = 3'b000,
      ST_WRITE  = 3'b001,
      ST_WR_ERR = 3'b010,
      ST_NO_OP  = 3'b011,
      ST_READ   = 3'b100,
      ST_RD_ERR = 3'b101
   } fifo_state_t;

   // 3'b110 and 3'b111 have no meaning and are folded back to INIT.
   function automatic logic state_legal(input logic [2:0] code);
      return (code <= 3'(ST_RD_ERR));
   endfunction

endpackage

// File: rtl/fifo_state_reg.sv
// Registered FIFO control state with illegal-code-to-INIT folding; strobe/error flags registered alongside.
// Latency: one clock from next_state to state and flags; no backpressure, loads every cycle.
module fifo_state_reg
   import fifo_state_addr_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] next_state,
   output logic [2:0] state,
   output logic       wr_flag,
   output logic       rd_flag,
   output logic       wr_err,
   output logic       rd_err
);

   fifo_state_t load_state;

   always_comb begin
      load_state = ST_INIT;
      if (state_legal(next_state)) begin
         load_state = fifo_state_t'(next_state);
      end
   end

   // Flags are decoded from the value being loaded so they track state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= 3'(ST_INIT);
         wr_flag <= 1'b0;
         rd_flag <= 1'b0;
         wr_err  <= 1'b0;
         rd_err  <= 1'b0;
      end else begin
         state   <= 3'(load_state);
         wr_flag <= (load_state == ST_WRITE);
         rd_flag <= (load_state == ST_READ);
         wr_err  <= (load_state == ST_WR_ERR);
         rd_err  <= (load_state == ST_RD_ERR);
      end
   end

endmodule

// File: rtl/fifo_state_addr.sv
// FIFO state register plus head/tail/count engine and memory strobe decode.
// Latency: one clock from next_state to state, strobes and addresses; no backpressure, overflow/underflow requests are dropped.
module fifo_state_addr
   import fifo_state_addr_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW,
   parameter int CW    = FIFO_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    next_state,
   output logic [2:0]    state,
   output logic [CW-1:0] data_count,
   output logic [AW-1:0] head,
   output logic [AW-1:0] tail,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic          we,
   output logic          re,
   output logic          full,
   output logic          empty,
   output logic          wr_ack,
   output logic          wr_err,
   output logic          rd_ack,
   output logic          rd_err
);

   logic wr_flag;
   logic rd_flag;
   logic wr_go;
   logic rd_go;

   fifo_state_reg u_state_reg (
      .clk        (clk),
      .reset      (reset),
      .next_state (next_state),
      .state      (state),
      .wr_flag    (wr_flag),
      .rd_flag    (rd_flag),
      .wr_err     (wr_err),
      .rd_err     (rd_err)
   );

   // A WRITE into a full FIFO or READ from an empty one still changes state but moves nothing.
   assign wr_go = (next_state == 3'(ST_WRITE)) && (data_count < CW'(DEPTH));
   assign rd_go = (next_state == 3'(ST_READ))  && (data_count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         data_count <= '0;
      end else if (wr_go) begin
         wr_addr    <= tail;
         tail       <= tail + AW'(1);
         data_count <= data_count + CW'(1);
      end else if (rd_go) begin
         rd_addr    <= head;
         head       <= head + AW'(1);
         data_count <= data_count - CW'(1);
      end
   end

   assign we     = wr_flag;
   assign wr_ack = wr_flag;
   assign re     = rd_flag;
   assign rd_ack = rd_flag;
   assign full   = (data_count == CW'(DEPTH));
   assign empty  = (data_count == '0);

endmodule

// File: tb/tb_fifo_state_addr.sv
// Directed vectors for fifo_state_addr; expectations queued at drive time, checked by a monitor after each edge.
module tb_fifo_state_addr;

   localparam logic [2:0] S_INIT = 3'b000, S_WR = 3'b001, S_WRE = 3'b010, S_NOP = 3'b011,
                          S_RD = 3'b100, S_RDE = 3'b101;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] next_state;
   logic [2:0] state;
   logic [3:0] data_count;
   logic [2:0] head, tail, wr_addr, rd_addr;
   logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [3:0] cnt;
      logic [2:0] hd;
      logic [2:0] tl;
      logic [2:0] wa;
      logic [2:0] ra;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fifo_state_addr dut (
      .clk        (clk),
      .reset      (reset),
      .next_state (next_state),
      .state      (state),
      .data_count (data_count),
      .head       (head),
      .tail       (tail),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .we         (we),
      .re         (re),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   // Drive one cycle, queue what the registers must hold after the coming edge.
   task automatic step(input logic rst, input logic [2:0] ns, input string name,
                       input logic [2:0] st, input logic [3:0] cnt, input logic [2:0] hd,
                       input logic [2:0] tl, input logic [2:0] wa, input logic [2:0] ra);
      exp_t e;
      reset      = rst;
      next_state = ns;
      e.name = name; e.st = st; e.cnt = cnt; e.hd = hd; e.tl = tl; e.wa = wa; e.ra = ra;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: outputs are valid every cycle, so each edge retires one queued expectation.
   initial begin
      exp_t       e;
      logic [7:0] fl_act, fl_exp;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            fl_act = {we, wr_ack, re, rd_ack, wr_err, rd_err, full, empty};
            fl_exp = {e.st == S_WR, e.st == S_WR, e.st == S_RD, e.st == S_RD,
                      e.st == S_WRE, e.st == S_RDE, e.cnt == 4'd8, e.cnt == 4'd0};
            checks++;
            if ({state, data_count, head, tail, wr_addr, rd_addr, fl_act} !==
                {e.st, e.cnt, e.hd, e.tl, e.wa, e.ra, fl_exp}) begin
               failures++;
               $display("FAIL %s: got st=%0d cnt=%0d head=%0d tail=%0d wa=%0d ra=%0d flags=%b, required st=%0d cnt=%0d head=%0d tail=%0d wa=%0d ra=%0d flags=%b",
                        e.name, state, data_count, head, tail, wr_addr, rd_addr, fl_act,
                        e.st, e.cnt, e.hd, e.tl, e.wa, e.ra, fl_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cyc;
      reset      = 1'b1;
      next_state = S_WR;
      #2;

      // Reset dominates a pending WRITE
      step(1, S_WR, "reset0", S_INIT, 0, 0, 0, 0, 0);
      step(1, S_WR, "reset1", S_INIT, 0, 0, 0, 0, 0);

      // Fill 8 entries; tail wraps back to 0
      for (int i = 0; i < 8; i++)
         step(0, S_WR, $sformatf("fill%0d", i), S_WR, 4'(i + 1), 0, 3'((i + 1) % 8), 3'(i), 0);

      step(0, S_WR,  "write_full", S_WR,  8, 0, 0, 7, 0);
      step(0, S_WRE, "wr_err",     S_WRE, 8, 0, 0, 7, 0);

      // Drain 8 entries
      for (int i = 0; i < 8; i++)
         step(0, S_RD, $sformatf("drain%0d", i), S_RD, 4'(7 - i), 3'((i + 1) % 8), 0, 7, 3'(i));

      step(0, S_RDE, "rd_err",     S_RDE, 0, 0, 0, 7, 7);
      step(0, S_RD,  "read_empty", S_RD,  0, 0, 0, 7, 7);

      // Wrap: write 5, read 3, write 6, read 1
      for (int i = 0; i < 5; i++)
         step(0, S_WR, $sformatf("wrap_w5_%0d", i), S_WR, 4'(i + 1), 0, 3'(i + 1), 3'(i), 7);
      for (int i = 0; i < 3; i++)
         step(0, S_RD, $sformatf("wrap_r3_%0d", i), S_RD, 4'(4 - i), 3'(i + 1), 5, 4, 3'(i));
      for (int i = 0; i < 6; i++)
         step(0, S_WR, $sformatf("wrap_w6_%0d", i), S_WR, 4'(3 + i), 3, 3'((6 + i) % 8), 3'((5 + i) % 8), 2);
      step(0, S_RD,  "wrap_r1", S_RD,  7, 4, 3, 2, 3);
      step(0, S_NOP, "no_op",   S_NOP, 7, 4, 3, 2, 3);

      // Reset lands on a cycle that would otherwise write
      step(0, S_WR, "pre_rst_wr", S_WR,   8, 4, 4, 3, 3);
      step(1, S_WR, "mid_reset",  S_INIT, 0, 0, 0, 0, 0);

      // Illegal codes fall back to INIT without touching pointers
      step(0, S_WR,   "ill_w0",   S_WR,   1, 0, 1, 0, 0);
      step(0, S_WR,   "ill_w1",   S_WR,   2, 0, 2, 1, 0);
      step(0, 3'b111, "ill_111",  S_INIT, 2, 0, 2, 1, 0);
      step(0, 3'b110, "ill_110",  S_INIT, 2, 0, 2, 1, 0);
      step(0, S_WR,   "ill_after", S_WR,  3, 0, 3, 2, 0);

      next_state = S_NOP;
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 5) begin
         @(posedge clk);
         wait_cyc++;
      end
      #3;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_queue: %0d expectations left unchecked, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
